hilo_unit: RTL and testbench
============================

# hilo_unit

HI/LO register unit and multiply/divide sequencer for the 54-instruction CPU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and computes products in a single cycle. It drives the external 32-cycle unsigned divider through a start/busy/over handshake, applying sign pre/post-correction for signed DIV. It writes quotient/remainder into LO/HI and stalls the pipeline while a division is in flight.

## Interface
Parameters: none.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op_valid  in  1  operation presented this cycle
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- rs_data  in  32  dividend / multiplicand / MTHI-MTLO source
- rt_data  in  32  divisor / multiplier
- stall  out  1  unit busy; new ops not accepted
- hi  out  32  HI register
- lo  out  32  LO register
- div_start  out  1  single-cycle start pulse to divider
- div_dividend  out  32  unsigned dividend to divider
- div_divisor  out  32  unsigned divisor to divider
- div_q  in  32  divider quotient, valid while div_over=1
- div_r  in  32  divider remainder, valid while div_over=1
- div_busy  in  1  divider busy (monitoring only)
- div_over  in  1  divider completion pulse, one cycle

## Operation
- Reset values: hi=0, lo=0, stall=0, div_start=0, div_dividend=0, div_divisor=0, state IDLE.
- Op acceptance: only in IDLE with op_valid=1. op_valid while stall=1 is ignored; the CPU holds the op.
- MULTU: {hi,lo} <= rs*rt unsigned, written at the accepting edge.
- MULT: {hi,lo} <= signed 64-bit product, same timing.
- MTHI: hi <= rs. MTLO: lo <= rs. Same timing.
- DIVU/DIV with rt=0: no divider launch. hi <= rs, lo <= 0xFFFFFFFF at the accepting edge; no stall.
- DIVU, rt≠0: latch div_dividend=rs, div_divisor=rt; state -> LAUNCH.
- DIV, rt≠0: latch magnitudes |rs|, |rt| (two's-complement negate if bit31 set; 0x80000000 maps to itself as unsigned). Record neg_q = rs[31]^rt[31] and neg_r = rs[31]; state -> LAUNCH.
- FSM:
  - IDLE -> LAUNCH on an accepted divide with nonzero divisor.
  - LAUNCH: div_start=1 for exactly this cycle; -> WAIT.
  - WAIT: on div_over=1 at an edge, lo <= neg_q ? -div_q : div_q and hi <= neg_r ? -div_r : div_r; -> IDLE.
- stall = (state != IDLE), driven combinationally from the state register.
- div_over while in IDLE or LAUNCH is ignored.
- Signed overflow (0x80000000 / 0xFFFFFFFF): magnitudes 0x80000000/1, neg_q=0, giving lo=0x80000000, hi=0.
- Reset mid-division forces IDLE, clears hi/lo, and drops stall. The divider shares the same reset.

## Timing
- Divider contract: samples start at edge; busy high for 32 cycles; over high the following cycle with q/r valid. start must not be held high.
- Divide accepted at edge E0 -> LAUNCH cycle -> divider samples start at E1 -> over high after E33 -> hi/lo written at E34.
- stall high from after E0 through E34: 34 cycles. The next op is accepted at E35.
- MULT/MULTU/MTHI/MTLO/zero-divisor ops: hi/lo valid one edge after acceptance, zero stall cycles.
- Back-to-back single-cycle ops are accepted every cycle.

## Structure
- Package hilo_pkg holds:
  - op encoding constants (OP_NONE..OP_MTLO)
  - state enum (IDLE, LAUNCH, WAIT)
  - constant DIV_LATENCY=32 for the bench
- Sub-module sign_fix: combinational conditional two's-complement negate of 32 bits. Instantiated for |rs|, |rt|, quotient fixup and remainder fixup.
- 64-bit multiply is inferred inline.
- The divider is instantiated by the parent, not inside this unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after one edge; stall never high.
- MULT 0xFFFFFFFE × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; then MTHI 0x1234 next cycle -> hi=0x1234, lo unchanged.
- DIVU 100/7 -> div_start high exactly one cycle; stall high 34 cycles; lo=14, hi=2; a DIVU presented mid-wait is not accepted.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> hi=5, lo=0xFFFFFFFF after one edge; no div_start, no stall.
- Reset asserted 10 cycles into WAIT -> stall=0, hi=lo=0 immediately; DIVU 9/3 after release -> lo=3, hi=0 after 35 edges.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: op encodings, sequencer states and
// the divider latency the surrounding system is built around.
package hilo_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int DIV_LATENCY = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// Bundle of the execute-stage op bus and the external divider handshake.
// master = CPU/divider side, slave = the HI/LO unit.
interface hilo_unit_if;

  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_busy;
  logic        div_over;

  modport master (
    output op_valid, op, rs_data, rt_data, div_q, div_r, div_busy, div_over,
    input  stall, hi, lo, div_start, div_dividend, div_divisor
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, div_q, div_r, div_busy, div_over,
    output stall, hi, lo, div_start, div_dividend, div_divisor
  );

endinterface

// File: rtl/hilo_unit_sign_fix.sv
// Conditional two's-complement negate; 0x80000000 negates to itself, which is
// the correct unsigned magnitude of the most negative value.
module sign_fix (
  input  logic        i_neg,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  assign o_data = i_neg ? (~i_data + 32'd1) : i_data;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO registers with single-cycle multiply and a sequencer that drives an
// external 32-cycle unsigned divider, adding sign correction for signed DIV.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  hilo_unit_if.slave bus
);

  state_t r_state;
  state_t w_state_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_stall;
  logic        w_div_start;
  logic        w_accept;
  logic        w_div_launch;

  logic [31:0] w_abs_rs;
  logic [31:0] w_abs_rt;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;

  logic [63:0]        w_prod_u;
  logic signed [63:0] w_rs_s;
  logic signed [63:0] w_rt_s;
  logic signed [63:0] w_prod_s;

  logic w_unused_busy;
  assign w_unused_busy = bus.div_busy;

  assign w_accept     = (r_state == IDLE) && bus.op_valid;
  assign w_div_launch = w_accept && is_div_op(bus.op) && (bus.rt_data != 32'd0);

  sign_fix u_abs_rs (.i_neg(bus.rs_data[31]), .i_data(bus.rs_data), .o_data(w_abs_rs));
  sign_fix u_abs_rt (.i_neg(bus.rt_data[31]), .i_data(bus.rt_data), .o_data(w_abs_rt));
  sign_fix u_fix_q  (.i_neg(r_neg_q),         .i_data(bus.div_q),   .o_data(w_fix_q));
  sign_fix u_fix_r  (.i_neg(r_neg_r),         .i_data(bus.div_r),   .o_data(w_fix_r));

  // Sign-extending to 64 bits first makes the truncated product the full signed result.
  assign w_prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};
  assign w_rs_s   = {{32{bus.rs_data[31]}}, bus.rs_data};
  assign w_rt_s   = {{32{bus.rt_data[31]}}, bus.rt_data};
  assign w_prod_s = w_rs_s * w_rt_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_div_launch) w_state_next = LAUNCH;
      LAUNCH:  w_state_next = WAIT;
      WAIT:    if (bus.div_over) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_stall     = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      IDLE:    ;
      LAUNCH:  begin w_stall = 1'b1; w_div_start = 1'b1; end
      WAIT:    w_stall = 1'b1;
      default: w_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else if (w_accept) begin
      case (bus.op)
        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
        OP_MTHI:  r_hi <= bus.rs_data;
        OP_MTLO:  r_lo <= bus.rs_data;
        OP_DIV, OP_DIVU: begin
          if (bus.rt_data == 32'd0) begin
            // Divide by zero completes immediately without touching the divider.
            r_hi <= bus.rs_data;
            r_lo <= 32'hFFFF_FFFF;
          end else if (bus.op == OP_DIV) begin
            r_dividend <= w_abs_rs;
            r_divisor  <= w_abs_rt;
            r_neg_q    <= bus.rs_data[31] ^ bus.rt_data[31];
            r_neg_r    <= bus.rs_data[31];
          end else begin
            r_dividend <= bus.rs_data;
            r_divisor  <= bus.rt_data;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end else if ((r_state == WAIT) && bus.div_over) begin
      r_lo <= w_fix_q;
      r_hi <= w_fix_r;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.div_start    = w_div_start;
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;
  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = r_divisor;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural 32-cycle divider model.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  hilo_unit_if bus ();

  hilo_unit dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Divider model: start sampled at an edge, busy for DIV_LATENCY cycles, then over for one.
  logic [31:0] m_a, m_b, m_q, m_r;
  logic        m_busy, m_over;
  int          m_cnt;
  logic        inj_over = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_a <= '0; m_b <= '0; m_q <= '0; m_r <= '0;
      m_busy <= 1'b0; m_over <= 1'b0; m_cnt <= 0;
    end else begin
      m_over <= 1'b0;
      if (bus.div_start && !m_busy) begin
        m_a <= bus.div_dividend; m_b <= bus.div_divisor;
        m_busy <= 1'b1; m_cnt <= DIV_LATENCY;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_over <= 1'b1;
          m_q <= (m_b != 0) ? m_a / m_b : 32'hFFFF_FFFF;
          m_r <= (m_b != 0) ? m_a % m_b : m_a;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign bus.div_busy = m_busy;
  assign bus.div_over = m_over | inj_over;
  assign bus.div_q    = inj_over ? 32'hDEAD_0001 : m_q;
  assign bus.div_r    = inj_over ? 32'hBEEF_0002 : m_r;

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
  endtask

  task automatic idle_bus();
    bus.op_valid = 1'b0; bus.op = OP_NONE; bus.rs_data = '0; bus.rt_data = '0;
  endtask

  // Issues one divide and counts stall/start samples until stall falls (bounded).
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stall_n, output int start_n, output bit timeout);
    @(negedge clock); drive(op, a, b);
    @(negedge clock); idle_bus();
    stall_n = 0; start_n = 0; timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.stall) begin timeout = 1'b0; break; end
      stall_n++;
      if (bus.div_start) start_n++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    vectors++; if (bus.div_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", bus.div_start); end
    vectors++; if (bus.div_dividend !== 32'd0) begin miscompares++; $display("FAIL reset_dividend got %h want 0", bus.div_dividend); end
    vectors++; if (bus.div_divisor !== 32'd0) begin miscompares++; $display("FAIL reset_divisor got %h want 0", bus.div_divisor); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_multu();
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL multu_stall_pre got %b want 0", bus.stall); end
    @(negedge clock); idle_bus();
    vectors++; if (bus.hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    vectors++; if (bus.lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL multu_stall got %b want 0", bus.stall); end
  endtask

  task automatic test_mult_mthi();
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    @(negedge clock);
    vectors++; if (bus.hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", bus.lo); end
    drive(OP_MTHI, 32'h0000_1234, 32'h0);
    @(negedge clock); idle_bus();
    vectors++; if (bus.hi !== 32'h0000_1234) begin miscompares++; $display("FAIL mthi_hi got %h want 00001234", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mthi_lo got %h want fffffffa", bus.lo); end
  endtask

  task automatic test_back_to_back();
    drive(OP_MTLO, 32'h0000_A5A5, 32'h0);
    @(negedge clock);
    vectors++; if (bus.lo !== 32'h0000_A5A5) begin miscompares++; $display("FAIL b2b_mtlo got %h want 0000a5a5", bus.lo); end
    vectors++; if (bus.hi !== 32'h0000_1234) begin miscompares++; $display("FAIL b2b_mtlo_hi got %h want 00001234", bus.hi); end
    drive(OP_MTHI, 32'h0000_5A5A, 32'h0);
    @(negedge clock);
    vectors++; if (bus.hi !== 32'h0000_5A5A) begin miscompares++; $display("FAIL b2b_mthi got %h want 00005a5a", bus.hi); end
    drive(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    @(negedge clock); idle_bus();
    vectors++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin miscompares++; $display("FAIL b2b_multu got %h_%h want 00000001_00000000", bus.hi, bus.lo); end
  endtask

  task automatic test_divu();
    int  stall_n, start_n, first_start;
    bit  timeout;
    @(negedge clock); drive(OP_DIVU, 32'd100, 32'd7);
    @(negedge clock); idle_bus();
    stall_n = 0; start_n = 0; first_start = -1; timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.stall) begin timeout = 1'b0; break; end
      stall_n++;
      if (bus.div_start) begin start_n++; if (first_start < 0) first_start = i; end
      if (i == 10) drive(OP_DIVU, 32'd50, 32'd5);
      if (i == 13) idle_bus();
      if (i == 12) begin
        vectors++; if (bus.div_dividend !== 32'd100 || bus.div_divisor !== 32'd7) begin
          miscompares++; $display("FAIL divu_midwait_latch got %0d/%0d want 100/7", bus.div_dividend, bus.div_divisor); end
      end
      @(negedge clock);
    end
    vectors++; if (timeout) begin miscompares++; $display("FAIL divu_timeout stall still high want low"); end
    vectors++; if (stall_n !== 34) begin miscompares++; $display("FAIL divu_stall_cycles got %0d want 34", stall_n); end
    vectors++; if (start_n !== 1 || first_start !== 0) begin miscompares++; $display("FAIL divu_start got %0d pulses at %0d want 1 at 0", start_n, first_start); end
    vectors++; if (bus.lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo got %0d want 14", bus.lo); end
    vectors++; if (bus.hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi got %0d want 2", bus.hi); end
    @(negedge clock);
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL divu_no_relaunch got stall %b want 0", bus.stall); end
  endtask

  task automatic test_div_signed();
    int stall_n, start_n;
    bit timeout;
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, stall_n, start_n, timeout);
    vectors++; if (timeout || stall_n !== 34) begin miscompares++; $display("FAIL div_m7_2_stall got %0d want 34", stall_n); end
    vectors++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL div_m7_2 got lo=%h hi=%h want lo=fffffffd hi=ffffffff", bus.lo, bus.hi); end
    run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, stall_n, start_n, timeout);
    vectors++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
      miscompares++; $display("FAIL div_7_m2 got lo=%h hi=%h want lo=fffffffd hi=00000001", bus.lo, bus.hi); end
    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stall_n, start_n, timeout);
    vectors++; if (bus.div_dividend !== 32'h8000_0000 || bus.div_divisor !== 32'd1) begin
      miscompares++; $display("FAIL div_ovf_mag got %h/%h want 80000000/00000001", bus.div_dividend, bus.div_divisor); end
    vectors++; if (timeout || bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
      miscompares++; $display("FAIL div_ovf got lo=%h hi=%h want lo=80000000 hi=00000000", bus.lo, bus.hi); end
  endtask

  task automatic test_spurious_over();
    @(negedge clock); inj_over = 1'b1;
    @(negedge clock); inj_over = 1'b0;
    vectors++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
      miscompares++; $display("FAIL idle_over got lo=%h hi=%h want lo=80000000 hi=00000000", bus.lo, bus.hi); end
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL idle_over_stall got %b want 0", bus.stall); end
  endtask

  task automatic test_div_zero();
    int starts = 0;
    @(negedge clock); drive(OP_DIVU, 32'd5, 32'd0);
    @(negedge clock); idle_bus();
    vectors++; if (bus.hi !== 32'd5 || bus.lo !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL divzero got hi=%h lo=%h want hi=00000005 lo=ffffffff", bus.hi, bus.lo); end
    for (int i = 0; i < 4; i++) begin
      if (bus.stall || bus.div_start) starts++;
      @(negedge clock);
    end
    vectors++; if (starts !== 0) begin miscompares++; $display("FAIL divzero_stall got %0d busy cycles want 0", starts); end
  endtask

  task automatic test_reset_mid();
    int stall_n, start_n;
    bit timeout;
    @(negedge clock); drive(OP_DIVU, 32'd1000, 32'd3);
    @(negedge clock); idle_bus();
    repeat (11) @(negedge clock);
    vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_stall got %b want 1", bus.stall); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL rstmid_stall got %b want 0", bus.stall); end
    vectors++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      miscompares++; $display("FAIL rstmid_hilo got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
    @(negedge clock); reset = 1'b0;
    run_div(OP_DIVU, 32'd9, 32'd3, stall_n, start_n, timeout);
    vectors++; if (timeout || stall_n !== 34 || start_n !== 1) begin
      miscompares++; $display("FAIL rstmid_div stall=%0d start=%0d want 34/1", stall_n, start_n); end
    vectors++; if (bus.lo !== 32'd3 || bus.hi !== 32'd0) begin
      miscompares++; $display("FAIL rstmid_result got lo=%0d hi=%0d want 3/0", bus.lo, bus.hi); end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_multu();
    test_mult_mthi();
    test_back_to_back();
    test_divu();
    test_div_signed();
    test_spurious_over();
    test_div_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
